// File: rtl/adc_sdram_writer.sv
// ADC capture engine: packs 16-bit samples into 32-bit words, buffers them,
// and streams them to consecutive SDRAM word addresses over Avalon-MM.
module adc_sdram_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 26
) (
    input  logic              in_clk_clk,
    input  logic              in_rst_reset_n,
    input  logic [15:0]       sample_data,
    input  logic              sample_valid,
    input  logic              capture_start,
    input  logic [ADDR_W-1:0] capture_base,
    input  logic [ADDR_W-1:0] capture_len,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable_n,
    output logic              avm_chipselect,
    output logic [31:0]       avm_writedata,
    output logic              avm_read_n,
    output logic              avm_write_n,
    input  logic              avm_waitrequest
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr, rptr, rptr_nx;
    logic [AW:0]       count;
    logic              half;
    logic [15:0]       lo_sample;
    logic [ADDR_W-1:0] words_packed;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] cur_addr;
    logic              wr_pend;

    logic start_ok, pop, full, fifo_empty;
    logic word_done, push, drop, last_push;

    assign start_ok   = capture_start &&
                        (state == S_IDLE || state == S_DONE);
    assign pop        = wr_pend && !avm_waitrequest;
    assign full       = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign word_done  = (state == S_CAPTURE) && sample_valid && half;
    assign push       = word_done && (!full || pop);
    assign drop       = word_done && full && !pop;
    assign last_push  = push && (words_packed + ADDR_W'(1) == len_r);
    assign rptr_nx    = rptr + AW'(1);

    assign busy             = (state == S_CAPTURE) || (state == S_DRAIN);
    assign done             = (state == S_DONE);
    assign avm_write_n      = !wr_pend;
    assign avm_chipselect   = wr_pend;
    assign avm_read_n       = 1'b1;
    assign avm_byteenable_n = 4'b0000;

    always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
        if (!in_rst_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_nx = (capture_len == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (last_push) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty && !wr_pend) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Sample packing; a completed word is either pushed or dropped.
    always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
        if (!in_rst_reset_n) begin
            half         <= 1'b0;
            lo_sample    <= '0;
            words_packed <= '0;
            len_r        <= '0;
            overflow     <= 1'b0;
        end else if (start_ok) begin
            half         <= 1'b0;
            words_packed <= '0;
            len_r        <= capture_len;
            overflow     <= 1'b0;
        end else if (state == S_CAPTURE && sample_valid) begin
            if (!half) begin
                lo_sample <= sample_data;
                half      <= 1'b1;
            end else begin
                half <= 1'b0;
                if (push) words_packed <= words_packed + ADDR_W'(1);
                if (drop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk_clk) begin
        if (push) mem[wptr] <= {sample_data, lo_sample};
    end

    always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
        if (!in_rst_reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr_nx;
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
        if (!in_rst_reset_n) begin
            cur_addr <= '0;
        end else if (start_ok) begin
            cur_addr <= capture_base;
        end else if (pop) begin
            cur_addr <= cur_addr + ADDR_W'(1);
        end
    end

    // Head is held in FIFO until accepted; the next word chains back-to-back.
    always_ff @(posedge in_clk_clk or negedge in_rst_reset_n) begin
        if (!in_rst_reset_n) begin
            wr_pend       <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else if (pop) begin
            if (count > (AW+1)'(1)) begin
                wr_pend       <= 1'b1;
                avm_writedata <= mem[rptr_nx];
                avm_address   <= cur_addr + ADDR_W'(1);
            end else begin
                wr_pend <= 1'b0;
            end
        end else if (!wr_pend && !fifo_empty) begin
            wr_pend       <= 1'b1;
            avm_writedata <= mem[rptr];
            avm_address   <= cur_addr;
        end
    end

endmodule

// File: tb/tb_adc_sdram_writer.sv
// Randomized self-checking bench for adc_sdram_writer with an Avalon slave
// model and a sample-pairing reference model.
module tb_adc_sdram_writer;

    localparam int AW    = 26;
    localparam int DEPTH = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [15:0]   sample_data = '0;
    logic          sample_valid = 0;
    logic          capture_start = 0;
    logic [AW-1:0] capture_base = '0;
    logic [AW-1:0] capture_len = '0;
    logic          busy, done, overflow;
    logic [AW-1:0] avm_address;
    logic [3:0]    avm_byteenable_n;
    logic          avm_chipselect;
    logic [31:0]   avm_writedata;
    logic          avm_read_n, avm_write_n;
    logic          avm_waitrequest = 0;

    int checks = 0;
    int errors = 0;

    int          stream_left = 0;
    bit          stream_rand = 0;
    logic [15:0] next_val = '0;
    logic [15:0] samples [$];
    logic [AW-1:0] wr_addr [$];
    logic [31:0] wr_data [$];

    bit hold_wait = 0;
    bit wait_rand = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    bit prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    int strobe_cnt = 0;
    int busy_cnt = 0;

    adc_sdram_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .in_clk_clk       (clk),
        .in_rst_reset_n   (rst_n),
        .sample_data      (sample_data),
        .sample_valid     (sample_valid),
        .capture_start    (capture_start),
        .capture_base     (capture_base),
        .capture_len      (capture_len),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow),
        .avm_address      (avm_address),
        .avm_byteenable_n (avm_byteenable_n),
        .avm_chipselect   (avm_chipselect),
        .avm_writedata    (avm_writedata),
        .avm_read_n       (avm_read_n),
        .avm_write_n      (avm_write_n),
        .avm_waitrequest  (avm_waitrequest)
    );

    always #5 clk = ~clk;

    // Sample source
    always @(negedge clk) begin
        if (stream_left > 0 &&
            (!stream_rand || $urandom_range(1, 0) == 1)) begin
            sample_valid = 1;
            sample_data  = next_val;
            samples.push_back(next_val);
            next_val++;
            stream_left--;
        end else begin
            sample_valid = 0;
            sample_data  = 16'($urandom);
        end
    end

    // Avalon slave: decides waitrequest for the coming edge, logs accepts
    always @(negedge clk) begin
        bit w;
        if (!rst_n) begin
            avm_waitrequest = 0;
            prev_stall = 0;
            stall_cnt = 0;
        end else begin
            checks++;
            if (avm_chipselect !== !avm_write_n ||
                avm_read_n !== 1'b1 || avm_byteenable_n !== 4'b0000) begin
                errors++;
                $display("FAIL bus_static cs=%b wr_n=%b rd_n=%b be_n=%b",
                         avm_chipselect, avm_write_n, avm_read_n,
                         avm_byteenable_n);
            end
            if (busy) busy_cnt++;
            if (!avm_write_n) begin
                strobe_cnt++;
                if (prev_stall) begin
                    checks++;
                    if (avm_address !== prev_addr ||
                        avm_writedata !== prev_data) begin
                        errors++;
                        $display("FAIL stall_stable got %h@%h want %h@%h",
                                 avm_writedata, avm_address,
                                 prev_data, prev_addr);
                    end
                end
                if (hold_wait) begin
                    w = 1;
                end else if (stall_cnt < stall_n) begin
                    w = 1;
                    stall_cnt++;
                end else if (wait_rand && $urandom_range(2, 0) == 0) begin
                    w = 1;
                end else begin
                    w = 0;
                end
                if (!w) begin
                    wr_addr.push_back(avm_address);
                    wr_data.push_back(avm_writedata);
                    stall_cnt = 0;
                end
                avm_waitrequest = w;
                prev_stall = w;
                prev_addr = avm_address;
                prev_data = avm_writedata;
            end else begin
                avm_waitrequest = $urandom_range(1, 0) == 1;
                prev_stall = 0;
            end
        end
    end

    // Reference: k-th word is the k-th pair of samples given since start
    function automatic logic [31:0] pair(int k);
        if (2 * k + 1 >= samples.size()) return 32'hxxxx_xxxx;
        return {samples[2*k+1], samples[2*k]};
    endfunction

    function automatic bit prefix_eq(int len);
        if (wr_data.size() != len) return 0;
        for (int i = 0; i < len; i++)
            if (wr_data[i] !== pair(i)) return 0;
        return 1;
    endfunction

    function automatic bit is_subseq();
        int k = 0;
        foreach (wr_data[i]) begin
            while (2 * k + 1 < samples.size() && pair(k) !== wr_data[i]) k++;
            if (2 * k + 1 >= samples.size()) return 0;
            k++;
        end
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap(input logic [AW-1:0] b, input logic [AW-1:0] l);
        samples.delete();
        wr_addr.delete();
        wr_data.delete();
        tick();
        capture_base  = b;
        capture_len   = l;
        capture_start = 1;
        tick();
        capture_start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0 || overflow !== 0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b want 000",
                     busy, done, overflow);
        end
        checks++;
        if (avm_write_n !== 1 || avm_chipselect !== 0 || avm_read_n !== 1) begin
            errors++;
            $display("FAIL reset_strobes wr_n=%b cs=%b rd_n=%b want 1 0 1",
                     avm_write_n, avm_chipselect, avm_read_n);
        end
        checks++;
        if (avm_address !== '0 || avm_writedata !== '0 ||
            avm_byteenable_n !== 4'b0000) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h be_n=%b want zeros",
                     avm_address, avm_writedata, avm_byteenable_n);
        end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic run_basic(input logic [AW-1:0] b, input string nm);
        bit ok;
        start_cap(b, 4);
        checks++;
        if (busy !== 1) begin
            errors++;
            $display("FAIL %s_busy got %b want 1", nm, busy);
        end
        next_val = 16'h0001;
        stream_rand = 0;
        stream_left = 8;
        wait_done(400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout done never rose", nm);
        end
        checks++;
        if (wr_data.size() != 4) begin
            errors++;
            $display("FAIL %s_count got %0d want 4", nm, wr_data.size());
        end
        for (int i = 0; i < wr_data.size() && i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== AW'(b + i) || wr_data[i] !== pair(i)) begin
                errors++;
                $display("FAIL %s_word%0d got %h@%h want %h@%h", nm, i,
                         wr_data[i], wr_addr[i], pair(i), AW'(b + i));
            end
        end
        checks++;
        if (wr_data.size() > 3 && wr_data[3] !== 32'h0008_0007) begin
            errors++;
            $display("FAIL %s_last got %h want 00080007", nm, wr_data[3]);
        end
        checks++;
        if (overflow !== 0) begin
            errors++;
            $display("FAIL %s_ovf got %b want 0", nm, overflow);
        end
    endtask

    task automatic test_basic();
        run_basic(26'h100, "basic");
    endtask

    task automatic test_wrap();
        run_basic(26'h3FF_FFFE, "wrap");
        checks++;
        if (wr_addr.size() == 4 && wr_addr[2] !== 26'h0) begin
            errors++;
            $display("FAIL wrap_zero got %h want 0000000", wr_addr[2]);
        end
    endtask

    task automatic test_stall();
        bit ok = 0;
        stall_n = 3;
        start_cap(26'h100, 4);
        next_val = 16'h0001;
        stream_left = 8;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || wr_data.size() != 4) begin
            errors++;
            $display("FAIL stall_done_early done=%b writes=%0d want 1 4",
                     ok, wr_data.size());
        end
        for (int i = 0; i < wr_data.size() && i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== AW'(26'h100 + i) || wr_data[i] !== pair(i)) begin
                errors++;
                $display("FAIL stall_word%0d got %h@%h want %h@%h", i,
                         wr_data[i], wr_addr[i], pair(i), AW'(26'h100 + i));
            end
        end
        stall_n = 0;
    endtask

    task automatic test_len_zero();
        strobe_cnt = 0;
        busy_cnt = 0;
        start_cap(26'h55, 0);
        checks++;
        if (done !== 1) begin
            errors++;
            $display("FAIL len0_done got %b want 1", done);
        end
        repeat (6) tick();
        checks++;
        if (strobe_cnt != 0 || busy_cnt != 0 || done !== 1) begin
            errors++;
            $display("FAIL len0_quiet strobes=%0d busy=%0d done=%b want 0 0 1",
                     strobe_cnt, busy_cnt, done);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        start_cap(26'h200, 8);
        hold_wait = 1;
        next_val = 16'h1000;
        stream_left = 2000;
        repeat (40) tick();
        hold_wait = 0;
        wait_done(600, ok);
        stream_left = 0;
        checks++;
        if (!ok || overflow !== 1) begin
            errors++;
            $display("FAIL ovf_flag done=%b ovf=%b want 1 1", ok, overflow);
        end
        checks++;
        if (wr_data.size() != 8) begin
            errors++;
            $display("FAIL ovf_count got %0d want 8", wr_data.size());
        end
        for (int i = 0; i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== AW'(26'h200 + i)) begin
                errors++;
                $display("FAIL ovf_addr%0d got %h want %h", i, wr_addr[i],
                         AW'(26'h200 + i));
            end
        end
        checks++;
        if (!is_subseq() || wr_data.size() < 4 || wr_data[0] !== pair(0) ||
            wr_data[3] !== pair(3)) begin
            errors++;
            $display("FAIL ovf_order first=%h want %h", wr_data[0], pair(0));
        end
    endtask

    task automatic test_reset_drain();
        start_cap(26'h300, 4);
        hold_wait = 1;
        next_val = 16'h2000;
        stream_left = 8;
        repeat (14) tick();
        checks++;
        if (busy !== 1 || avm_write_n !== 0) begin
            errors++;
            $display("FAIL rstdrain_pre busy=%b wr_n=%b want 1 0",
                     busy, avm_write_n);
        end
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (avm_write_n !== 1 || avm_chipselect !== 0 || busy !== 0 ||
            done !== 0 || overflow !== 0) begin
            errors++;
            $display("FAIL rstdrain_out wr_n=%b cs=%b b=%b d=%b o=%b",
                     avm_write_n, avm_chipselect, busy, done, overflow);
        end
        hold_wait = 0;
        tick();
        rst_n = 1;
        strobe_cnt = 0;
        repeat (10) tick();
        checks++;
        if (strobe_cnt != 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL rstdrain_quiet strobes=%0d busy=%b done=%b",
                     strobe_cnt, busy, done);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [AW-1:0] b;
        int len;
        for (int it = 0; it < 6; it++) begin
            b = (it == 0) ? 26'h3FF_FFFA : AW'($urandom);
            len = $urandom_range(12, 1);
            wait_rand = 1;
            stream_rand = 1;
            start_cap(b, AW'(len));
            next_val = 16'($urandom);
            stream_left = 2000;
            wait_done(3000, ok);
            stream_left = 0;
            checks++;
            if (!ok || wr_data.size() != len) begin
                errors++;
                $display("FAIL rand%0d_count done=%b got %0d want %0d",
                         it, ok, wr_data.size(), len);
            end
            for (int i = 0; i < wr_addr.size(); i++) begin
                checks++;
                if (wr_addr[i] !== AW'(b + i)) begin
                    errors++;
                    $display("FAIL rand%0d_addr%0d got %h want %h", it, i,
                             wr_addr[i], AW'(b + i));
                end
            end
            checks++;
            if (!is_subseq()) begin
                errors++;
                $display("FAIL rand%0d_order words not in sample order", it);
            end
            checks++;
            if (overflow !== !prefix_eq(len)) begin
                errors++;
                $display("FAIL rand%0d_ovf got %b want %b", it, overflow,
                         !prefix_eq(len));
            end
        end
        wait_rand = 0;
        stream_rand = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_wrap();
        test_overflow();
        test_reset_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
